// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog: enable, ratio load handshake and divided outputs.
interface clk_div_prog_if #(
  parameter int unsigned DIV_W = 16
);
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             clk_div;
  logic             tick;
  logic             div_ack;
  logic             div_err;

  modport master (
    output en, div_val, div_load,
    input  clk_div, tick, div_ack, div_err
  );

  modport slave (
    input  en, div_val, div_load,
    output clk_div, tick, div_ack, div_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (N >= 2) with per-period tick and load ack/err pulses.
// Define CLK_DIV_ODD50_EN to add a negedge stage giving exact 50% duty for odd ratios.
module clk_div_prog #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_DEF = 50000
) (
  input logic           clk,
  input logic           rst_n,
  clk_div_prog_if.slave bus
);

  localparam logic [DIV_W-1:0] DefRatio = DIV_W'(DIV_DEF);
  localparam logic [DIV_W-1:0] One      = DIV_W'(1);
  localparam logic [DIV_W-1:0] Two      = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_cur_q, n_cur_d;
  logic [DIV_W-1:0] n_pend_q, n_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             q_pos, q_pos_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt_inc;
  logic             wrap;
  logic             load_ok;

  always_comb begin
    half    = n_cur_q >> 1;
    cnt_inc = cnt_q + One;
    wrap    = (cnt_q == n_cur_q - One);
    load_ok = bus.div_load && (bus.div_val >= Two);

    cnt_d      = cnt_q;
    n_cur_d    = n_cur_q;
    n_pend_d   = n_pend_q;
    pend_vld_d = pend_vld_q;
    q_pos_d    = q_pos;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = bus.div_load && (bus.div_val < Two);

    if (bus.en) begin
      if (wrap) begin
        cnt_d   = '0;
        q_pos_d = 1'b0;
        // A pending ratio only ever takes over at a period boundary.
        if (pend_vld_q) begin
          n_cur_d    = n_pend_q;
          pend_vld_d = 1'b0;
          ack_d      = 1'b1;
        end
      end else begin
        cnt_d   = cnt_inc;
        q_pos_d = (cnt_inc >= half);
        tick_d  = (cnt_inc == half);
      end
    end

    // Applied after the wrap logic so a same-edge load stays pending for the next wrap.
    if (load_ok) begin
      n_pend_d   = bus.div_val;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      n_cur_q    <= DefRatio;
      n_pend_q   <= DefRatio;
      pend_vld_q <= 1'b0;
      q_pos      <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      n_cur_q    <= n_cur_d;
      n_pend_q   <= n_pend_d;
      pend_vld_q <= pend_vld_d;
      q_pos      <= q_pos_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic q_neg;

  // Half-cycle delayed copy; ANDing it in delays the rising edge for odd ratios only.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
    end else begin
      q_neg <= q_pos;
    end
  end

  assign bus.clk_div = n_cur_q[0] ? (q_pos & q_neg) : q_pos;
`else
  assign bus.clk_div = q_pos;
`endif

  assign bus.tick    = tick_q;
  assign bus.div_ack = ack_q;
  assign bus.div_err = err_q;

endmodule
